hs_slot_sync: RTL and testbench

//  Generalised high-score save/restore controller for arcade cores. Maps N core-RAM regions into one

---
 rtl/hs_slot_sync.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_hs_slot_sync.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_slot_sync.sv
// High-score save/restore controller: maps core-RAM regions into one bridge byte window and
// sequences the dataslot restore/seed/save handshake. Optional autosave: define HS_AUTOSAVE_EN.
module hs_slot_sync #(
    parameter int                                NUM_REGIONS     = 2,
    parameter int                                HS_ADDR_W       = 12,
    parameter logic [NUM_REGIONS*HS_ADDR_W-1:0]  REGION_BASE     = {12'h57e, 12'h620},
    parameter logic [NUM_REGIONS*8-1:0]          REGION_LEN      = {8'd3, 8'd80},
    parameter logic [31:0]                       BRIDGE_BASE     = 32'h1000_0000,
    parameter logic [15:0]                       SLOT_ID         = 16'd2,
    parameter logic [9:0]                        DT_INDEX        = 10'd5,
    parameter logic [31:0]                       START_DELAY     = 32'h2349_3400,
    parameter logic [23:0]                       ACK_TIMEOUT     = 24'hFF_FFFF,
    parameter logic [31:0]                       AUTOSAVE_PERIOD = 32'(36'h4_6000_0000 >> 4)
) (
    input  logic                 clk_74a,
    input  logic                 reset,
    input  logic                 core_running,
    input  logic [31:0]          bridge_addr,
    input  logic [31:0]          bridge_wr_data,
    input  logic                 bridge_wr,
    input  logic                 bridge_rd,
    output logic [31:0]          bridge_rd_data,
    output logic                 selected,
    output logic [9:0]           datatable_addr,
    output logic [31:0]          datatable_data,
    output logic                 datatable_wren,
    input  logic [31:0]          datatable_q,
    output logic                 target_dataslot_read,
    output logic                 target_dataslot_write,
    input  logic                 target_dataslot_ack,
    output logic [15:0]          target_dataslot_id,
    output logic [31:0]          target_dataslot_slotoffset,
    output logic [31:0]          target_dataslot_bridgeaddr,
    output logic [31:0]          target_dataslot_length,
    output logic                 processor_halt,
    output logic [HS_ADDR_W-1:0] hs_address,
    output logic                 hs_write_enable,
    output logic [7:0]           hs_data_in,
    input  logic [7:0]           hs_data_out,
    input  logic                 save_req,
    output logic                 busy,
    output logic                 error
);

    function automatic int calc_total();
        int s;
        s = 0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            s = s + int'(REGION_LEN[r*8 +: 8]);
        end
        return s;
    endfunction

    localparam int         TOTAL_LEN   = calc_total();
    localparam logic [7:0] TOTAL_LEN_B = 8'(TOTAL_LEN);

    // Window offset -> core-RAM address: first region whose cumulative end exceeds the offset.
    function automatic logic [HS_ADDR_W-1:0] map_addr(input logic [7:0] off);
        int                   start;
        int                   len;
        logic                 found;
        logic [HS_ADDR_W-1:0] a;
        start = 0;
        found = 1'b0;
        a     = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            len = int'(REGION_LEN[r*8 +: 8]);
            if (!found && (int'(off) < start + len)) begin
                a     = REGION_BASE[r*HS_ADDR_W +: HS_ADDR_W] + HS_ADDR_W'(int'(off) - start);
                found = 1'b1;
            end
            start = start + len;
        end
        return a;
    endfunction

    function automatic logic in_range(input logic [7:0] off);
        return off < TOTAL_LEN_B;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign selected                   = (bridge_addr[31:8] == BRIDGE_BASE[31:8]);
    assign datatable_addr             = DT_INDEX;
    assign datatable_data             = 32'(TOTAL_LEN);
    assign target_dataslot_id         = SLOT_ID;
    assign target_dataslot_slotoffset = 32'h0;
    assign target_dataslot_bridgeaddr = BRIDGE_BASE;
    assign target_dataslot_length     = 32'(TOTAL_LEN);

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bridge_addr[1:0];

    // ------------------------------------------------------------------
    // Bridge byte sequencer
    // ------------------------------------------------------------------
    logic                 seq_act_q, seq_act_d;
    logic                 seq_wr_q, seq_wr_d;
    logic [1:0]           seq_idx_q, seq_idx_d;
    logic [7:0]           seq_off_q, seq_off_d;
    logic [31:0]          seq_wdata_q, seq_wdata_d;
    logic [HS_ADDR_W-1:0] hs_address_q, hs_address_d;
    logic                 hs_we_q, hs_we_d;
    logic [7:0]           hs_din_q, hs_din_d;
    logic                 rd_vld_p0_q, rd_vld_p0_d;
    logic                 rd_oor_p0_q, rd_oor_p0_d;
    logic                 rd_last_p0_q, rd_last_p0_d;
    logic                 rd_vld_p1_q, rd_oor_p1_q, rd_last_p1_q;
    logic                 rd_last_p2_q, rd_last_p2_d;
    logic [31:0]          shift_q, shift_d;
    logic [31:0]          bridge_rd_data_q, bridge_rd_data_d;

    logic        start;
    logic [7:0]  cur_off;
    logic [1:0]  cur_idx;
    logic        cur_wr;
    logic [31:0] cur_wdata;
    logic        issue;

    always_comb begin
        start     = (bridge_wr | bridge_rd) & selected & ~seq_act_q;
        cur_off   = start ? {bridge_addr[7:2], 2'b00} : seq_off_q + 8'(seq_idx_q);
        cur_idx   = start ? 2'd0 : seq_idx_q;
        cur_wr    = start ? bridge_wr : seq_wr_q;
        cur_wdata = start ? bridge_wr_data : seq_wdata_q;
        issue     = start | seq_act_q;

        seq_act_d   = seq_act_q;
        seq_wr_d    = seq_wr_q;
        seq_idx_d   = seq_idx_q;
        seq_off_d   = seq_off_q;
        seq_wdata_d = seq_wdata_q;
        if (start) begin
            seq_act_d   = 1'b1;
            seq_wr_d    = bridge_wr;
            seq_idx_d   = 2'd1;
            seq_off_d   = {bridge_addr[7:2], 2'b00};
            seq_wdata_d = bridge_wr_data;
        end else if (seq_act_q) begin
            seq_idx_d = seq_idx_q + 2'd1;
            if (seq_idx_q == 2'd3) begin
                seq_act_d = 1'b0;
            end
        end

        hs_address_d = issue ? map_addr(cur_off) : hs_address_q;
        hs_we_d      = issue & cur_wr & in_range(cur_off);
        hs_din_d     = issue ? byte_of(cur_wdata, cur_idx) : hs_din_q;
        rd_vld_p0_d  = issue & ~cur_wr;
        rd_oor_p0_d  = ~in_range(cur_off);
        rd_last_p0_d = (cur_idx == 2'd3);

        shift_d          = shift_q;
        if (rd_vld_p1_q) begin
            shift_d = {shift_q[23:0], (rd_oor_p1_q ? 8'h00 : hs_data_out)};
        end
        rd_last_p2_d     = rd_vld_p1_q & rd_last_p1_q;
        bridge_rd_data_d = rd_last_p2_q ? shift_q : bridge_rd_data_q;
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            seq_act_q        <= 1'b0;
            seq_wr_q         <= 1'b0;
            seq_idx_q        <= 2'd0;
            hs_address_q     <= '0;
            hs_we_q          <= 1'b0;
            hs_din_q         <= 8'h00;
            rd_vld_p0_q      <= 1'b0;
            rd_oor_p0_q      <= 1'b0;
            rd_last_p0_q     <= 1'b0;
            rd_vld_p1_q      <= 1'b0;
            rd_oor_p1_q      <= 1'b0;
            rd_last_p1_q     <= 1'b0;
            rd_last_p2_q     <= 1'b0;
            bridge_rd_data_q <= 32'h0;
        end else begin
            seq_act_q        <= seq_act_d;
            seq_wr_q         <= seq_wr_d;
            seq_idx_q        <= seq_idx_d;
            hs_address_q     <= hs_address_d;
            hs_we_q          <= hs_we_d;
            hs_din_q         <= hs_din_d;
            rd_vld_p0_q      <= rd_vld_p0_d;
            rd_oor_p0_q      <= rd_oor_p0_d;
            rd_last_p0_q     <= rd_last_p0_d;
            // p0 -> p1: RAM read data for the p0 address is now on hs_data_out
            rd_vld_p1_q      <= rd_vld_p0_q;
            rd_oor_p1_q      <= rd_oor_p0_q;
            rd_last_p1_q     <= rd_last_p0_q;
            rd_last_p2_q     <= rd_last_p2_d;
            bridge_rd_data_q <= bridge_rd_data_d;
        end
    end

    always_ff @(posedge clk_74a) begin
        seq_off_q   <= seq_off_d;
        seq_wdata_q <= seq_wdata_d;
        shift_q     <= shift_d;
    end

    assign hs_address      = hs_address_q;
    assign hs_write_enable = hs_we_q;
    assign hs_data_in      = hs_din_q;
    assign bridge_rd_data  = bridge_rd_data_q;

    // ------------------------------------------------------------------
    // Dataslot control FSM
    // ------------------------------------------------------------------
    typedef enum logic [3:0] {
        ST_IDLE, ST_SIZE_RD, ST_CHECK, ST_SIZE_WR, ST_LOAD,
        ST_SAVE, ST_ACK_HI, ST_ACK_LO, ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        error_q, error_d;
    logic        rd_pulse_q, rd_pulse_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic        wren_q, wren_d;
    logic        auto_tick;

`ifdef HS_AUTOSAVE_EN
    logic [31:0] auto_cnt_q, auto_cnt_d;

    // Held at the reload value outside DONE, so every entry to DONE restarts the period.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (state_q != ST_DONE) begin
            auto_cnt_d = AUTOSAVE_PERIOD - 32'd1;
        end else if (auto_cnt_q != 32'd0) begin
            auto_cnt_d = auto_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            auto_cnt_q <= AUTOSAVE_PERIOD - 32'd1;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign auto_tick = (state_q == ST_DONE) && (auto_cnt_q == 32'd0);
`else
    logic unused_autosave;
    assign unused_autosave = ^AUTOSAVE_PERIOD;
    assign auto_tick       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (!core_running) begin
                    cnt_d = START_DELAY;
                end else if (cnt_q == 32'd0) begin
                    state_d = ST_SIZE_RD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SIZE_RD: state_d = ST_CHECK;
            ST_CHECK: begin
                if (datatable_q == 32'd0) begin
                    state_d = ST_SIZE_WR;
                end else if (datatable_q == 32'(TOTAL_LEN)) begin
                    state_d = ST_LOAD;
                end else begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_SIZE_WR: state_d = ST_SAVE;
            ST_LOAD, ST_SAVE: begin
                state_d = ST_ACK_HI;
                cnt_d   = {8'h00, ACK_TIMEOUT};
            end
            ST_ACK_HI: begin
                if (target_dataslot_ack) begin
                    state_d = ST_ACK_LO;
                    cnt_d   = {8'h00, ACK_TIMEOUT};
                end else if (cnt_q == 32'd0) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_ACK_LO: begin
                if (!target_dataslot_ack) begin
                    state_d = ST_DONE;
                end else if (cnt_q == 32'd0) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_DONE: begin
                if (save_req || auto_tick) begin
                    state_d = ST_SAVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing the core aborts whatever is in flight; the error flag survives.
        if (!core_running) begin
            state_d = ST_IDLE;
            cnt_d   = START_DELAY;
        end

        rd_pulse_d = (state_d == ST_LOAD);
        wr_pulse_d = (state_d == ST_SAVE);
        wren_d     = (state_d == ST_SIZE_WR);
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= START_DELAY;
            error_q    <= 1'b0;
            rd_pulse_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            error_q    <= error_d;
            rd_pulse_q <= rd_pulse_d;
            wr_pulse_q <= wr_pulse_d;
            wren_q     <= wren_d;
        end
    end

    assign processor_halt        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign busy                  = processor_halt;
    assign error                 = error_q;
    assign target_dataslot_read  = rd_pulse_q;
    assign target_dataslot_write = wr_pulse_q;
    assign datatable_wren        = wren_q;

endmodule

// File: tb/tb_hs_slot_sync.sv
// Self-checking bench for hs_slot_sync: bridge window vectors, randomized bridge traffic
// against a byte-map reference model, and hand-written dataslot handshake sequences.
module tb_hs_slot_sync;

    localparam int SD    = 10;
    localparam int AT    = 20;
    localparam int AP    = 100;
    localparam int TOTAL = 83;

    logic        clk_74a = 1'b0;
    always #5 clk_74a = ~clk_74a;

    logic        reset;
    logic        core_running;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        bridge_wr;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic        selected;
    logic [9:0]  datatable_addr;
    logic [31:0] datatable_data;
    logic        datatable_wren;
    logic [31:0] datatable_q;
    logic        target_dataslot_read;
    logic        target_dataslot_write;
    logic        target_dataslot_ack;
    logic [15:0] target_dataslot_id;
    logic [31:0] target_dataslot_slotoffset;
    logic [31:0] target_dataslot_bridgeaddr;
    logic [31:0] target_dataslot_length;
    logic        processor_halt;
    logic [11:0] hs_address;
    logic        hs_write_enable;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        save_req;
    logic        busy;
    logic        error;

    hs_slot_sync #(
        .START_DELAY     (32'(SD)),
        .ACK_TIMEOUT     (24'(AT)),
        .AUTOSAVE_PERIOD (32'(AP))
    ) dut (
        .clk_74a                    (clk_74a),
        .reset                      (reset),
        .core_running               (core_running),
        .bridge_addr                (bridge_addr),
        .bridge_wr_data             (bridge_wr_data),
        .bridge_wr                  (bridge_wr),
        .bridge_rd                  (bridge_rd),
        .bridge_rd_data             (bridge_rd_data),
        .selected                   (selected),
        .datatable_addr             (datatable_addr),
        .datatable_data             (datatable_data),
        .datatable_wren             (datatable_wren),
        .datatable_q                (datatable_q),
        .target_dataslot_read       (target_dataslot_read),
        .target_dataslot_write      (target_dataslot_write),
        .target_dataslot_ack        (target_dataslot_ack),
        .target_dataslot_id         (target_dataslot_id),
        .target_dataslot_slotoffset (target_dataslot_slotoffset),
        .target_dataslot_bridgeaddr (target_dataslot_bridgeaddr),
        .target_dataslot_length     (target_dataslot_length),
        .processor_halt             (processor_halt),
        .hs_address                 (hs_address),
        .hs_write_enable            (hs_write_enable),
        .hs_data_in                 (hs_data_in),
        .hs_data_out                (hs_data_out),
        .save_req                   (save_req),
        .busy                       (busy),
        .error                      (error)
    );

    // Core RAM with one-cycle read latency
    logic [7:0] mem [0:4095];
    logic       mem_clr;
    always @(posedge clk_74a) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (hs_write_enable) begin
            mem[hs_address] <= hs_data_in;
        end
        hs_data_out <= mem[hs_address];
    end

    // Datatable word with one-cycle read latency
    logic [31:0] dt_val;
    logic        dt_set;
    logic [31:0] dt_set_val;
    always @(posedge clk_74a) begin
        if (dt_set) dt_val <= dt_set_val;
        else if (datatable_wren && datatable_addr == 10'd5) dt_val <= datatable_data;
        datatable_q <= dt_val;
    end

    // Pulse counters
    int   n_rd, n_wr, n_wren;
    logic mon_clr;
    always @(posedge clk_74a) begin
        if (mon_clr) begin
            n_rd <= 0; n_wr <= 0; n_wren <= 0;
        end else begin
            if (target_dataslot_read)  n_rd   <= n_rd + 1;
            if (target_dataslot_write) n_wr   <= n_wr + 1;
            if (datatable_wren)        n_wren <= n_wren + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    // Reference model: window offset -> RAM address table, and a shadow copy of RAM
    logic [11:0] addr_tab [0:255];
    logic [7:0]  shadow   [0:4095];

    task automatic build_model();
        int o;
        int bases [2];
        int lens  [2];
        bases = '{32'h620, 32'h57e};
        lens  = '{80, 3};
        o = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < lens[r]; i++) begin
                addr_tab[o] = 12'(bases[r] + i);
                o++;
            end
        end
        for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [31:0] w;
        int          o;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            o = int'(off) + k;
            w = w << 8;
            if (o < TOTAL) w[7:0] = shadow[addr_tab[o]];
        end
        return w;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] wd);
        int o;
        for (int k = 0; k < 4; k++) begin
            o = int'(off) + k;
            if (o < TOTAL) shadow[addr_tab[o]] = wd[31 - 8*k -: 8];
        end
    endtask

    task automatic bridge_op(input logic wr, input logic [7:0] off, input logic [31:0] wd,
                             output logic [31:0] rd);
        bridge_addr    = 32'h1000_0000 | {24'h0, off};
        bridge_wr      = wr;
        bridge_rd      = ~wr;
        bridge_wr_data = wd;
        tick();
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
        repeat (6) tick();
        rd = bridge_rd_data;
        if (wr) model_write(off, wd);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        core_running = 1'b0;
        target_dataslot_ack = 1'b0;
        save_req     = 1'b0;
        mon_clr      = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic set_dt(input logic [31:0] v);
        dt_set     = 1'b1;
        dt_set_val = v;
        tick();
        dt_set = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] rdv;
    int          n;
    int          hcnt;

    initial begin
        bridge_addr = 32'h0; bridge_wr_data = 32'h0; bridge_wr = 1'b0; bridge_rd = 1'b0;
        dt_set = 1'b0; dt_set_val = 32'h0;
        mem_clr = 1'b1;
        build_model();
        do_reset();
        mem_clr = 1'b0;

        // Reset state
        chk("rst_halt", 32'(processor_halt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_rd_pulse", 32'(target_dataslot_read), 32'h0);
        chk("rst_wr_pulse", 32'(target_dataslot_write), 32'h0);
        chk("rst_wren", 32'(datatable_wren), 32'h0);
        chk("rst_rd_data", bridge_rd_data, 32'h0);
        chk("rst_hs_we", 32'(hs_write_enable), 32'h0);
        chk("const_dt_addr", 32'(datatable_addr), 32'd5);

        bridge_addr = 32'h1000_0044;
        #1 chk("selected_hit", 32'(selected), 32'h1);
        bridge_addr = 32'h1000_0144;
        #1 chk("selected_miss", 32'(selected), 32'h0);

        // Bridge window vectors
        vt[0] = '{1'b1, 8'h00, 32'hAABBCCDD, 32'h0};
        vt[1] = '{1'b0, 8'h00, 32'h0,        32'hAABBCCDD};
        vt[2] = '{1'b1, 8'h4C, 32'h11223344, 32'h0};
        vt[3] = '{1'b0, 8'h4C, 32'h0,        32'h11223344};
        vt[4] = '{1'b1, 8'h50, 32'h01020304, 32'h0};
        vt[5] = '{1'b0, 8'h50, 32'h0,        32'h01020300};
        vt[6] = '{1'b0, 8'hFC, 32'h0,        32'h00000000};
        vt[7] = '{1'b1, 8'hFC, 32'hDEADBEEF, 32'h0};
        vt[8] = '{1'b0, 8'hFC, 32'h0,        32'h00000000};
        vt[9] = '{1'b0, 8'h48, 32'h0,        32'h00000000};
        for (int i = 0; i < 10; i++) begin
            bridge_op(vt[i].wr, vt[i].off, vt[i].wd, rdv);
            if (!vt[i].wr) chk($sformatf("vec%0d_rd", i), rdv, vt[i].exp);
        end
        chk("ram_620", 32'(mem[12'h620]), 32'hAA);
        chk("ram_621", 32'(mem[12'h621]), 32'hBB);
        chk("ram_622", 32'(mem[12'h622]), 32'hCC);
        chk("ram_623", 32'(mem[12'h623]), 32'hDD);
        chk("ram_66f", 32'(mem[12'h66f]), 32'h44);
        chk("ram_57e", 32'(mem[12'h57e]), 32'h01);
        chk("ram_580", 32'(mem[12'h580]), 32'h03);
        chk("ram_581_dropped", 32'(mem[12'h581]), 32'h00);

        // A second strobe during an active sequence is ignored
        bridge_addr = 32'h1000_0020; bridge_wr_data = 32'h55667788; bridge_wr = 1'b1;
        tick();
        bridge_addr = 32'h1000_0024; bridge_wr_data = 32'h99999999;
        tick();
        bridge_wr = 1'b0;
        repeat (6) tick();
        model_write(8'h20, 32'h55667788);
        chk("overlap_640", 32'(mem[12'h640]), 32'h55);
        chk("overlap_643", 32'(mem[12'h643]), 32'h88);
        chk("overlap_644_untouched", 32'(mem[12'h644]), 32'h00);

        // Randomized bridge traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [7:0]  o;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            o = 8'($urandom_range(0, 63) * 4);
            d = $urandom;
            if (w) begin
                bridge_op(1'b1, o, d, rdv);
            end else begin
                bridge_op(1'b0, o, 32'h0, rdv);
                chk($sformatf("rand%0d_rd_off%0h", i, o), rdv, model_read(o));
            end
        end

        // Seed: empty slot -> size write then save
        do_reset();
        set_dt(32'h0);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        core_running = 1'b1;
        n = 0;
        while (processor_halt !== 1'b1 && n < 200) begin tick(); n++; end
        chk("seed_delay_to_halt", 32'(n), 32'(SD + 1));
        n = 0;
        while (datatable_wren !== 1'b1 && n < 10) begin tick(); n++; end
        chk("seed_wren_latency", 32'(n), 32'd2);
        chk("seed_dt_data", datatable_data, 32'd83);
        tick();
        chk("seed_wren_one_cycle", 32'(datatable_wren), 32'h0);
        chk("seed_wr_pulse", 32'(target_dataslot_write), 32'h1);
        tick();
        chk("seed_wr_pulse_end", 32'(target_dataslot_write), 32'h0);
        chk("seed_halt_ackhi", 32'(processor_halt), 32'h1);
        target_dataslot_ack = 1'b1;
        repeat (4) tick();
        chk("seed_halt_ack", 32'(processor_halt), 32'h1);
        target_dataslot_ack = 1'b0;
        tick();
        chk("seed_halt_done", 32'(processor_halt), 32'h0);
        chk("seed_busy_done", 32'(busy), 32'h0);
        chk("seed_error", 32'(error), 32'h0);
        chk("seed_n_rd", 32'(n_rd), 32'd0);
        chk("seed_n_wr", 32'(n_wr), 32'd1);
        chk("seed_n_wren", 32'(n_wren), 32'd1);
        chk("seed_dt_stored", dt_val, 32'd83);

        // save_req in DONE
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        chk("done_save_pulse", 32'(target_dataslot_write), 32'h1);
        tick();
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack = 1'b0;
        tick();
        chk("done_save_halt", 32'(processor_halt), 32'h0);
        chk("done_save_count", 32'(n_wr), 32'd2);
`ifdef HS_AUTOSAVE_EN
        n = 0;
        while (target_dataslot_write !== 1'b1 && n < 300) begin tick(); n++; end
        chk("autosave_period", 32'(n), 32'(AP));
        tick();
        target_dataslot_ack = 1'b1;
        tick();
        target_dataslot_ack = 1'b0;
        tick();
`endif
        core_running = 1'b0;
        tick();
        hcnt = n_wr;
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        repeat (3) tick();
        chk("idle_save_dropped", 32'(n_wr), 32'(hcnt));

        // Restore path with ack that never comes
        do_reset();
        set_dt(32'd83);
        core_running = 1'b1;
        n = 0;
        while (target_dataslot_read !== 1'b1 && n < 200) begin tick(); n++; end
        chk("load_latency", 32'(n), 32'(SD + 3));
        chk("load_id", 32'(target_dataslot_id), 32'd2);
        chk("load_length", target_dataslot_length, 32'd83);
        chk("load_slotoffset", target_dataslot_slotoffset, 32'h0);
        chk("load_bridgeaddr", target_dataslot_bridgeaddr, 32'h1000_0000);
        chk("load_halt", 32'(processor_halt), 32'h1);
        tick();
        n = 0;
        while (error !== 1'b1 && n < 200) begin tick(); n++; end
        chk("ack_timeout_cycles", 32'(n), 32'(AT + 1));
        chk("timeout_halt_released", 32'(processor_halt), 32'h0);
        chk("timeout_n_wr", 32'(n_wr), 32'd0);
        core_running = 1'b0;
        tick();
        chk("error_kept_after_core_stop", 32'(error), 32'h1);
        chk("core_stop_halt", 32'(processor_halt), 32'h0);

        // Size mismatch
        do_reset();
        chk("reset_clears_error", 32'(error), 32'h0);
        set_dt(32'd40);
        core_running = 1'b1;
        hcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (processor_halt) hcnt++;
        end
        chk("mismatch_error", 32'(error), 32'h1);
        chk("mismatch_halt_cycles", 32'(hcnt), 32'd2);
        chk("mismatch_no_rd", 32'(n_rd), 32'd0);
        chk("mismatch_no_wr", 32'(n_wr), 32'd0);
        chk("mismatch_no_wren", 32'(n_wren), 32'd0);

        // Reset during ACK_LO
        do_reset();
        set_dt(32'd83);
        core_running = 1'b1;
        n = 0;
        while (target_dataslot_read !== 1'b1 && n < 200) begin tick(); n++; end
        tick();
        target_dataslot_ack = 1'b1;
        tick();
        tick();
        chk("acklo_halt", 32'(processor_halt), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_acklo_halt", 32'(processor_halt), 32'h0);
        chk("reset_acklo_busy", 32'(busy), 32'h0);
        hcnt = n_rd;
        repeat (3) tick();
        target_dataslot_ack = 1'b0;
        chk("reset_acklo_stale_ack", 32'(processor_halt), 32'h0);
        chk("reset_acklo_no_error", 32'(error), 32'h0);

        // core_running falls while waiting for ack
        do_reset();
        set_dt(32'd83);
        core_running = 1'b1;
        n = 0;
        while (target_dataslot_read !== 1'b1 && n < 200) begin tick(); n++; end
        tick();
        core_running = 1'b0;
        tick();
        chk("core_drop_halt", 32'(processor_halt), 32'h0);
        chk("core_drop_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
